da_coef_loader: RTL and testbench
=================================

Name: da_coef_loader

Overview:
- Writer side of the DA filter's coefficient ROM.
- Accepts 64 signed filter taps over a valid/ready stream, eight taps per group.
- For each group, computes all 256 subset partial sums and writes them into the matching DA SRAM bank through CIN/CADDR/CLOAD, so the DA core can later read them as a lookup table.
- One adder/subtractor walks each bank in Gray-code order, producing one ROM write per cycle.

Parameters:
- COEF_W, 16, signed tap width; must be ≤17 so that 8*max|tap| fits the 20-bit CIN.
- NGROUP, 8, number of banks/groups; fixed to match the 3-bit bank field of CADDR.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse that begins a full 64-tap reload; ignored while busy=1.
- coef_in  in  COEF_W  signed tap; tap k arrives k-th after load_start, k=0..63.
- coef_valid  in  1  coef_in valid.
- coef_ready  out  1  loader can accept a tap.
- CIN  out  20  signed partial sum to write.
- CADDR  out  11  {bank[2:0], addr[7:0]}.
- CLOAD  out  1  write strobe: each cycle it is high, CIN is written to CADDR.
- busy  out  1  high from the cycle after an accepted load_start until done.
- done  out  1  one-cycle pulse after the final write of bank 7.

Behaviour:
- Reset (async, resetn=0):
  - State = IDLE.
  - coef_ready=0, CLOAD=0, busy=0, done=0, CIN=0, CADDR=0.
  - Internal tap registers h[0..7], group counter, step counter and running sum all cleared.
- Tap mapping:
  - Tap k goes to bank b=k>>3, bit j=k&7.
  - ROM entry at (b,a) = sum over j with a[j]=1 of h[8b+j], sign-extended to 20 bits.
  - Entry a=0 is 0.
- IDLE:
  - coef_ready=0.
  - On load_start=1: go to COLLECT, busy=1, group=0.
- COLLECT:
  - coef_ready=1.
  - Each cycle with coef_valid & coef_ready: h[cnt] <= coef_in, cnt++.
  - coef_valid=0 stalls; there is no timeout.
  - After the 8th accepted tap: coef_ready drops the next cycle, step i=0, sum=0, then go to GEN.
- GEN (256 cycles, coef_ready=0, CLOAD=1 every cycle):
  - Cycle i=0: CADDR={group,8'h00}, CIN=0.
  - Cycle i=1..255:
    - g=i^(i>>1); j=trailing-zero count of i.
    - sum <= sum + sext(h[j]) if g[j]=1, else sum - sext(h[j]).
    - CADDR={group,g}, CIN equals the new sum in that same write cycle (registered outputs; the sum is pre-computed one cycle ahead).
  - After i=255:
    - If group<7: group++, back to COLLECT.
    - Else: CLOAD=0, busy=0, done=1 for one cycle, go to IDLE.
- Throughput:
  - Minimum reload = 8*(8+256)=2112 cycles from the first accepted tap.
  - No bubbles inside GEN.
- Arithmetic:
  - 20-bit two's complement.
  - No overflow is possible for COEF_W≤17; no saturation logic.
- Simultaneous events:
  - load_start during busy is ignored.
  - coef_valid outside COLLECT is ignored; no tap is consumed.
- Reset mid-operation:
  - Immediate abort; CLOAD deasserts asynchronously.
  - Partially written ROM contents are undefined; a new load_start is required.
- CLOAD is high only in GEN, so the DA core sees writes only during a reload; the DA must not be started while busy=1.

Test Plan:
- All 64 taps = +1, no stalls:
  - bank 0 addr 8'hFF → CIN=8; addr 8'h05 → 2; addr 8'h00 → 0.
  - Exactly 2048 CLOAD cycles; done 1 cycle after the last write.
- Taps h[k]=k:
  - bank 1 addr 8'h03 → 8+9=17.
  - bank 7 addr 8'hFF → sum(56..63)=476.
  - Every (bank,addr) written exactly once.
- All taps = -32768 (COEF_W=16):
  - addr 8'hFF → 20'hC0000 (-262144).
  - addr 8'h01 → 20'hF8000.
- Random coef_valid gaps (50% duty) with random taps:
  - ROM scoreboard matches the reference subset sums.
  - coef_ready=0 throughout GEN.
  - CLOAD never high in COLLECT.
- load_start pulsed mid-GEN → ignored; sequence and write count unchanged.
- resetn asserted at group 3, step 100:
  - Outputs go to reset values immediately.
  - A later load_start performs a clean full reload.

Source files
------------

// File: rtl/da_coef_loader_if.sv
// Coefficient-loader bus: load control, tap stream (valid/ready) and DA ROM write port.
//   slave  : loader side (takes taps, drives ROM writes and status)
//   master : controller side (supplies taps, observes ROM writes and status)
// Signals:
//   load_start          reload request pulse
//   coef_in/coef_valid  signed tap stream, coef_ready is the loader's accept
//   CIN/CADDR/CLOAD     ROM write data, {bank, addr}, write strobe
//   busy/done           reload in progress / end-of-reload pulse
interface da_coef_loader_if #(
    parameter int unsigned COEF_W = 16
) ();
    logic                     load_start;
    logic signed [COEF_W-1:0] coef_in;
    logic                     coef_valid;
    logic                     coef_ready;
    logic        [19:0]       CIN;
    logic        [10:0]       CADDR;
    logic                     CLOAD;
    logic                     busy;
    logic                     done;

    modport slave (
        input  load_start, coef_in, coef_valid,
        output coef_ready, CIN, CADDR, CLOAD, busy, done
    );

    modport master (
        output load_start, coef_in, coef_valid,
        input  coef_ready, CIN, CADDR, CLOAD, busy, done
    );
endinterface

// File: rtl/da_coef_loader.sv
// Writer side of the DA filter coefficient ROM. Collects 64 signed taps in groups of eight;
// after each group it writes all 256 subset sums of the group into its bank, one write per
// cycle, walking the addresses in Gray-code order so each entry is one add/sub away from the
// previous one.
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     da_coef_loader_if.slave: load_start, coef_in/coef_valid/coef_ready,
//           CIN/CADDR/CLOAD write port, busy, done
module da_coef_loader #(
    parameter int unsigned COEF_W = 16,
    parameter int unsigned NGROUP = 8
) (
    input logic              clk,
    input logic              resetn,
    da_coef_loader_if.slave  bus
);

    localparam int unsigned SumW = 20;

    typedef enum logic [1:0] {StIdle, StCollect, StGen} state_e;

    state_e                   state_q, state_d;
    logic        [2:0]        group_q, group_d;
    logic        [2:0]        cnt_q, cnt_d;
    logic        [7:0]        step_q, step_d;
    logic signed [SumW-1:0]   sum_q, sum_d;
    logic        [10:0]       caddr_q, caddr_d;
    logic                     cload_q, cload_d;
    logic                     done_q, done_d;
    logic signed [COEF_W-1:0] h_q [8];

    logic                     tap_accept;
    logic        [7:0]        step_nxt;
    logic        [7:0]        gray_nxt;
    logic        [2:0]        tz;
    logic signed [COEF_W-1:0] h_sel;
    logic signed [SumW-1:0]   h_ext;

    always_comb begin
        state_d    = state_q;
        group_d    = group_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        sum_d      = sum_q;
        caddr_d    = caddr_q;
        cload_d    = 1'b0;
        done_d     = 1'b0;
        tap_accept = 1'b0;

        // Next entry: Gray address of step+1; the flipped bit is its trailing-zero count.
        step_nxt = step_q + 8'd1;
        gray_nxt = step_nxt ^ (step_nxt >> 1);
        tz       = 3'd0;
        for (int b = 7; b >= 0; b--) begin
            if (step_nxt[b]) tz = 3'(b);
        end
        h_sel = h_q[tz];
        h_ext = {{(SumW - COEF_W){h_sel[COEF_W-1]}}, h_sel};

        unique case (state_q)
            StIdle: begin
                if (bus.load_start) begin
                    state_d = StCollect;
                    group_d = 3'd0;
                    cnt_d   = 3'd0;
                end
            end
            StCollect: begin
                if (bus.coef_valid) begin
                    tap_accept = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        // Entry 0 is loaded here so CLOAD is high on the first GEN cycle.
                        state_d = StGen;
                        step_d  = 8'd0;
                        sum_d   = '0;
                        caddr_d = {group_q, 8'h00};
                        cload_d = 1'b1;
                    end
                end
            end
            StGen: begin
                if (step_q == 8'hFF) begin
                    if (group_q == 3'(NGROUP - 1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StCollect;
                        group_d = group_q + 3'd1;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    cload_d = 1'b1;
                    step_d  = step_nxt;
                    sum_d   = gray_nxt[tz] ? (sum_q + h_ext) : (sum_q - h_ext);
                    caddr_d = {group_q, gray_nxt};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            group_q <= 3'd0;
            cnt_q   <= 3'd0;
            step_q  <= 8'd0;
            sum_q   <= '0;
            caddr_q <= 11'd0;
            cload_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            group_q <= group_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            sum_q   <= sum_d;
            caddr_q <= caddr_d;
            cload_q <= cload_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) h_q[i] <= '0;
        end else if (tap_accept) begin
            h_q[cnt_q] <= bus.coef_in;
        end
    end

    assign bus.coef_ready = (state_q == StCollect);
    assign bus.busy       = (state_q != StIdle);
    assign bus.CIN        = sum_q;
    assign bus.CADDR      = caddr_q;
    assign bus.CLOAD      = cload_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_da_coef_loader.sv
module tb_da_coef_loader;

    logic clk;
    logic resetn;

    da_coef_loader_if #(.COEF_W(16)) bus ();

    da_coef_loader #(.COEF_W(16), .NGROUP(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    logic signed [15:0] taps [64];
    logic        [19:0] rom_cap [2048];
    int                 wr_cnt [2048];
    int                 wr_total;
    int                 done_cnt;
    int                 done_cyc;
    int                 last_wr;
    int                 cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ROM entry: sum of the group's taps selected by the address bits.
    function automatic logic [19:0] ref_entry(input int b, input int a);
        int s = 0;
        for (int j = 0; j < 8; j++) begin
            if (a[j]) s += int'(taps[8 * b + j]);
        end
        return 20'(s);
    endfunction

    function automatic int bad_entries();
        int n = 0;
        for (int i = 0; i < 2048; i++) if (wr_cnt[i] != 1) n++;
        return n;
    endfunction

    always @(negedge clk) begin
        if (resetn) begin
            cyc++;
            if (bus.CLOAD) begin
                check("cin", {12'd0, bus.CIN},
                      {12'd0, ref_entry(int'(bus.CADDR[10:8]), int'(bus.CADDR[7:0]))});
                check("ready_in_gen", {31'd0, bus.coef_ready}, 32'd0);
                check("busy_in_gen", {31'd0, bus.busy}, 32'd1);
                rom_cap[bus.CADDR] = bus.CIN;
                wr_cnt[bus.CADDR]++;
                wr_total++;
                last_wr = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_sb();
        for (int i = 0; i < 2048; i++) begin
            wr_cnt[i]  = 0;
            rom_cap[i] = '0;
        end
        wr_total = 0;
        done_cnt = 0;
        done_cyc = 0;
        last_wr  = 0;
    endtask

    task automatic start();
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    // Feeds taps in order; returns early once stop_at writes have been seen (0 = never).
    task automatic send_taps(input bit gaps, input int stop_at);
        int k = 0;
        int guard = 0;
        bit v;
        while (k < 64) begin
            @(negedge clk);
            #1;
            if (stop_at > 0 && wr_total >= stop_at) return;
            guard++;
            if (guard > 20000) begin
                check("send_timeout", k, 64);
                return;
            end
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.coef_valid = v;
            bus.coef_in    = v ? taps[k] : 16'($urandom);
            if (v && bus.coef_ready) k++;
        end
        @(negedge clk);
        bus.coef_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_seen", {31'd0, done_cnt > 0}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic run_load(input bit gaps, input bit mid_pulse);
        clear_sb();
        start();
        send_taps(gaps, 0);
        if (mid_pulse) begin
            repeat (100) @(negedge clk);
            bus.load_start = 1'b1;
            @(negedge clk);
            bus.load_start = 1'b0;
        end
        wait_done();
        check("write_count", wr_total, 2048);
        check("write_once", bad_entries(), 0);
        check("done_count", done_cnt, 1);
        check("done_after_last", done_cyc - last_wr, 1);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cload"}, {31'd0, bus.CLOAD}, 32'd0);
        check({tag, "_cin"}, {12'd0, bus.CIN}, 32'd0);
        check({tag, "_caddr"}, {21'd0, bus.CADDR}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.coef_ready}, 32'd0);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.load_start = 1'b0;
        bus.coef_valid = 1'b0;
        bus.coef_in    = '0;
        clear_sb();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        resetn = 1'b1;
        // Valid while idle must not be consumed or start anything.
        bus.coef_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", {31'd0, bus.coef_ready}, 32'd0);
        check("idle_no_busy", {31'd0, bus.busy}, 32'd0);
        bus.coef_valid = 1'b0;

        // All taps +1.
        for (int k = 0; k < 64; k++) taps[k] = 16'sd1;
        run_load(1'b0, 1'b0);
        check("t1_b0_ff", {12'd0, rom_cap[11'h0FF]}, 32'd8);
        check("t1_b0_05", {12'd0, rom_cap[11'h005]}, 32'd2);
        check("t1_b0_00", {12'd0, rom_cap[11'h000]}, 32'd0);

        // h[k] = k, with a load_start pulse during GEN.
        for (int k = 0; k < 64; k++) taps[k] = 16'(k);
        run_load(1'b0, 1'b1);
        check("t2_b1_03", {12'd0, rom_cap[11'h103]}, 32'd17);
        check("t2_b7_ff", {12'd0, rom_cap[11'h7FF]}, 32'd476);

        // Most negative taps.
        for (int k = 0; k < 64; k++) taps[k] = 16'sh8000;
        run_load(1'b0, 1'b0);
        check("t3_b0_ff", {12'd0, rom_cap[11'h0FF]}, 32'h000C0000);
        check("t3_b0_01", {12'd0, rom_cap[11'h001]}, 32'h000F8000);

        // Random taps with random valid gaps.
        for (int k = 0; k < 64; k++) taps[k] = 16'($urandom);
        run_load(1'b1, 1'b0);

        // Abort with reset while bank 3 step 100 is being written.
        for (int k = 0; k < 64; k++) taps[k] = 16'($urandom);
        clear_sb();
        start();
        send_taps(1'b0, 3 * 256 + 101);
        check("abort_point", wr_total, 3 * 256 + 101);
        check("abort_addr", {21'd0, bus.CADDR}, {21'd0, 3'd3, 8'd100 ^ 8'd50});
        resetn = 1'b0;
        #1;
        check_reset_outputs("abort");
        bus.coef_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 64; k++) taps[k] = 16'($urandom);
        run_load(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
